square_iter: RTL and testbench

- Parametrised, multi-cycle successor to the combinational 64-bit squarer.
- Computes out0 = in0*in0 for a WIDTH-bit operand.
- Processes DIGIT bits of the multiplier per clock, trading latency for area.
- Sits behind valid/ready handshakes so approximate-logic experiments can drop it into streaming datapaths.

---
 rtl/square_pkg.sv | 25 ++
 rtl/square_digit_mac.sv | 37 +++
 rtl/square_iter.sv | 156 +++++++++++++++
 tb/tb_square_iter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/square_pkg.sv
// Shared types and sizing helpers for the iterative squarer.
//   state_t      : controller states (IDLE, BUSY, DONE)
//   cycle_count  : number of compute cycles, WIDTH/DIGIT
//   cnt_width    : bits needed for the digit counter (at least 1)
package square_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cycle_count(input int width, input int digit);
      return width / digit;
   endfunction

   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/square_digit_mac.sv
// One digit step of the shift-and-add squarer (combinational).
// Kept separate so approximate arithmetic variants can be swapped in.
//   op       : WIDTH-bit multiplicand (the registered operand)
//   digit    : DIGIT-bit slice of the multiplier for this step
//   idx      : digit position; partial product is shifted by idx*DIGIT
//   acc      : running 2*WIDTH-bit sum
//   acc_next : acc + (op*digit << idx*DIGIT), full 2*WIDTH precision
module square_digit_mac #(
   parameter int WIDTH = 64,
   parameter int DIGIT = 4,
   parameter int CW    = 4
) (
   input  logic [WIDTH-1:0]   op,
   input  logic [DIGIT-1:0]   digit,
   input  logic [CW-1:0]      idx,
   input  logic [2*WIDTH-1:0] acc,
   output logic [2*WIDTH-1:0] acc_next
);

   localparam int SW = $clog2(2 * WIDTH) + 1;

   logic [2*WIDTH-1:0] op_ext_s;
   logic [2*WIDTH-1:0] dig_ext_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [SW-1:0]      shamt_s;

   // Partial product op*digit fits in WIDTH+DIGIT bits, so the 2*WIDTH
   // product never wraps; the shifted value stays inside the final square.
   always_comb begin
      op_ext_s  = {{WIDTH{1'b0}}, op};
      dig_ext_s = {{(2*WIDTH-DIGIT){1'b0}}, digit};
      prod_s    = op_ext_s * dig_ext_s;
      shamt_s   = SW'(idx) * SW'(DIGIT);
      acc_next  = acc + (prod_s << shamt_s);
   end

endmodule

// File: rtl/square_iter.sv
// Multi-cycle squarer: out0 = in0*in0, DIGIT multiplier bits per clock,
// N = WIDTH/DIGIT compute cycles, valid/ready on both sides.
//   clk, rst_n          : rising-edge clock, async active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in0                 : WIDTH-bit operand, registered on accept
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out0                : 2*WIDTH-bit result, registered, never partial
//   busy                : high in BUSY or DONE
// Optional build macro SQUARE_ITER_SIGNED_EN: in0 is two's complement and
// its magnitude is squared; otherwise in0 is unsigned.
module square_iter
   import square_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in0,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out0,
   output logic               busy
);

   localparam int N  = cycle_count(WIDTH, DIGIT);
   localparam int CW = cnt_width(N);

   generate
      if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("square_iter: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   state_t                   state_q, state_d;
   logic [WIDTH-1:0]         op_q, op_d;
   logic [2*WIDTH-1:0]       acc_q, acc_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [2*WIDTH-1:0]       out0_q, out0_d;
   logic                     in_ready_q, in_ready_d;
   logic                     out_valid_q, out_valid_d;
   logic                     busy_q, busy_d;

   logic [WIDTH-1:0]         op_in_s;
   logic [N-1:0][DIGIT-1:0]  op_digits_s;
   logic [DIGIT-1:0]         digit_s;
   logic [2*WIDTH-1:0]       acc_next_s;

   // Operand conditioning on accept: magnitude in the signed build.
   always_comb begin
`ifdef SQUARE_ITER_SIGNED_EN
      // -2^(WIDTH-1) negates to itself, which read as unsigned is 2^(WIDTH-1).
      if (in0[WIDTH-1]) begin
         op_in_s = ~in0 + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         op_in_s = in0;
      end
`else
      op_in_s = in0;
`endif
   end

   // Select the multiplier digit for the current step.
   always_comb begin
      op_digits_s = op_q;
      digit_s     = op_digits_s[cnt_q];
   end

   square_digit_mac #(
      .WIDTH (WIDTH),
      .DIGIT (DIGIT),
      .CW    (CW)
   ) u_mac (
      .op       (op_q),
      .digit    (digit_s),
      .idx      (cnt_q),
      .acc      (acc_q),
      .acc_next (acc_next_s)
   );

   // Controller next-state, datapath updates and registered-output decode.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      out0_d  = out0_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = op_in_s;
               acc_d   = {(2*WIDTH){1'b0}};
               cnt_d   = {CW{1'b0}};
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            acc_d = acc_next_s;
            if (cnt_q == CW'(N - 1)) begin
               // Only the completed sum ever reaches out0.
               out0_d  = acc_next_s;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Handshake outputs are registered from the next state.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= {WIDTH{1'b0}};
         acc_q       <= {(2*WIDTH){1'b0}};
         cnt_q       <= {CW{1'b0}};
         out0_q      <= {(2*WIDTH){1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out0_q      <= out0_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out0      = out0_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_square_iter.sv
module tb_square_iter;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in0;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out0;
   logic         busy;

   logic         s_in_valid;
   logic         s_in_ready;
   logic [7:0]   s_in0;
   logic         s_out_valid;
   logic         s_out_ready;
   logic [15:0]  s_out0;
   logic         s_busy;

   int checks;
   int errors;

   square_iter #(.WIDTH(64), .DIGIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in0       (in0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .busy      (busy)
   );

   square_iter #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in0       (s_in0),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .out0      (s_out0),
      .busy      (s_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Offer one operand while the DUT is idle; accepted at the next rising edge.
   task automatic send(input logic [63:0] v);
      @(negedge clk);
      in0      = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count rising edges until out_valid, bounded at 100.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic drain();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (out0 !== 128'd0) begin errors++; $display("FAIL reset_out0 got %h want 0", out0); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      send(64'd3);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%0b in_ready=%0b want 1/0", busy, in_ready); end
      wait_valid(lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
      checks++; if (out0 !== 128'd9) begin errors++; $display("FAIL basic_3 got %h want 9", out0); end
      drain();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_drain got v=%0b r=%0b b=%0b want 0/1/0", out_valid, in_ready, busy); end
      checks++; if (out0 !== 128'd9) begin errors++; $display("FAIL basic_hold got %h want 9", out0); end
      send(64'd0);
      wait_valid(lat);
      checks++; if (lat !== 16 || out0 !== 128'd0) begin errors++; $display("FAIL basic_0 got lat=%0d out0=%h want 16/0", lat, out0); end
      drain();
   endtask

   task automatic test_max();
      int lat;
      logic [127:0] exp;
`ifdef SQUARE_ITER_SIGNED_EN
      exp = 128'd1;
`else
      exp = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
`endif
      send(64'hFFFF_FFFF_FFFF_FFFF);
      wait_valid(lat);
      checks++; if (lat !== 16 || out0 !== exp) begin errors++; $display("FAIL max got lat=%0d out0=%h want 16/%h", lat, out0, exp); end
      drain();
   endtask

   task automatic test_backpressure();
      int lat;
      send(64'd5);
      wait_valid(lat);
      @(negedge clk);
      in0      = 64'd7;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out0 !== 128'd25 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d got out0=%h r=%0b v=%0b want 25/0/1", i, out0, in_ready, out_valid);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got v=%0b r=%0b b=%0b want 0/1/0", out_valid, in_ready, busy); end
      checks++; if (out0 !== 128'd25) begin errors++; $display("FAIL bp_out0 got %h want 25", out0); end
      // out_ready while idle must not disturb anything
      @(negedge clk);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out0 !== 128'd25) begin errors++; $display("FAIL bp_idle_ready got v=%0b b=%0b out0=%h", out_valid, busy, out0); end
   endtask

   task automatic test_reset_mid_busy();
      int lat;
      bit saw;
      send(64'd12345);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out0 !== 128'd0) begin errors++; $display("FAIL midrst_outputs got v=%0b r=%0b b=%0b out0=%h", out_valid, in_ready, busy, out0); end
      @(negedge clk);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) saw = 1'b1;
      end
      checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_no_result got %0b want 0", saw); end
      send(64'h1_0000_0000);
      wait_valid(lat);
      checks++; if (lat !== 16 || out0 !== 128'h1_0000_0000_0000_0000) begin errors++; $display("FAIL midrst_next got lat=%0d out0=%h", lat, out0); end
      drain();
   endtask

   task automatic test_width8();
      int lat;
      logic [15:0] exp;
`ifdef SQUARE_ITER_SIGNED_EN
      exp = 16'h0001;
`else
      exp = 16'hFE01;
`endif
      @(negedge clk);
      s_in0      = 8'hFF;
      s_in_valid = 1'b1;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      lat = 0;
      while (!s_out_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++; if (lat !== 1 || s_out0 !== exp) begin errors++; $display("FAIL w8_ff got lat=%0d out0=%h want 1/%h", lat, s_out0, exp); end
      @(negedge clk);
      s_out_ready = 1'b1;
      @(posedge clk);
      #1;
      s_out_ready = 1'b0;
      checks++; if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin errors++; $display("FAIL w8_drain got v=%0b r=%0b", s_out_valid, s_in_ready); end
      @(negedge clk);
      s_in0      = 8'h0F;
      s_in_valid = 1'b1;
      @(posedge clk);
      #1;
      s_in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (s_out_valid !== 1'b1 || s_out0 !== 16'd225) begin errors++; $display("FAIL w8_0f got v=%0b out0=%h want 1/00e1", s_out_valid, s_out0); end
      @(negedge clk);
      s_out_ready = 1'b1;
      @(posedge clk);
      #1;
      s_out_ready = 1'b0;
   endtask

   task automatic test_signed_vectors();
      int lat;
      logic [127:0] exp;
`ifdef SQUARE_ITER_SIGNED_EN
      exp = 128'd9;
`else
      exp = 128'hFFFF_FFFF_FFFF_FFFA_0000_0000_0000_0009;
`endif
      send(64'hFFFF_FFFF_FFFF_FFFD);
      wait_valid(lat);
      checks++; if (lat !== 16 || out0 !== exp) begin errors++; $display("FAIL neg3 got lat=%0d out0=%h want 16/%h", lat, out0, exp); end
      drain();
      send(64'h8000_0000_0000_0000);
      wait_valid(lat);
      checks++; if (out0 !== 128'h4000_0000_0000_0000_0000_0000_0000_0000) begin errors++; $display("FAIL minneg got %h want 4000..0", out0); end
      drain();
   endtask

   task automatic test_random();
      int lat;
      logic [63:0]  a;
      logic [63:0]  mag;
      logic [127:0] exp;
      for (int i = 0; i < 40; i++) begin
         a = {$urandom(), $urandom()};
         if (i % 4 == 0) a = a >> (i % 60);
`ifdef SQUARE_ITER_SIGNED_EN
         mag = a[63] ? (64'd0 - a) : a;
`else
         mag = a;
`endif
         exp = {64'd0, mag} * {64'd0, mag};
         send(a);
         // in0 changing during BUSY must not matter
         in0 = ~a;
         wait_valid(lat);
         checks++;
         if (lat !== 16 || out0 !== exp) begin
            errors++;
            $display("FAIL random[%0d] in0=%h got lat=%0d out0=%h want 16/%h", i, a, lat, out0, exp);
         end
         drain();
      end
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      in_valid    = 1'b0;
      in0         = 64'd0;
      out_ready   = 1'b0;
      s_in_valid  = 1'b0;
      s_in0       = 8'd0;
      s_out_ready = 1'b0;
      test_reset();
      test_basic();
      test_max();
      test_backpressure();
      test_reset_mid_busy();
      test_width8();
      test_signed_vectors();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
